mem_stage_access_unit: RTL
==========================

// Module: mem_stage_access_unit
// PURPOSE
// - MEM-stage consumer of the EX/MEM pipeline register outputs. Performs load/store
//   accesses on the data-memory request/ready bus and formats load data
//   (byte/half/word, sign/zero extend).
// - Drives mem_stall to hold the EX/MEM register and all upstream stages while an
//   access is outstanding.
// - Registers the WB-stage bundle: it is the MEM/WB boundary.
// PARAMETERS
// - DATA_WIDTH  32  data width (RV32I; only 32 supported)
// - ADDR_WIDTH  32  data-memory address width
// PORTS
// - clk             in   1   clock
// - rst             in   1   asynchronous, active-high reset
// - mem_alu_result  in   32  effective address or ALU result
// - mem_rs2_data    in   32  store data
// - mem_rd_addr     in   5   destination register
// - mem_funct3      in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - mem_MemRead / mem_MemWrite / mem_MemToReg / mem_RegWrite   in  1 each   EX/MEM controls
// - dmem_req        out  1   access request; held high until dmem_ready
// - dmem_we         out  1   1 = store
// - dmem_addr       out  32  word-aligned address ({addr[31:2],2'b00})
// - dmem_wdata      out  32  lane-replicated store data
// - dmem_be         out  4   byte enables (0 for loads)
// - dmem_ready      in   1   access complete; rdata valid in same cycle for loads
// - dmem_rdata      in   32  raw read word
// - mem_stall       out  1   1 = hold EX/MEM register (drives its enable low)
// - wb_valid        out  1   WB bundle valid
// - wb_RegWrite / wb_MemToReg   out  1 each
// - wb_rd_addr      out  5
// - wb_alu_result   out  32
// - wb_load_data    out  32  extended load data
// - mem_misaligned  out  1   misaligned access pulse (MEM_MISALIGN_TRAP_EN only)
// BEHAVIOUR
// Reset values:
// - Reset returns the FSM to IDLE.
// - All registered outputs reset to 0.
// - Reset mid-access drops dmem_req asynchronously and abandons the access.
// FSM:
// - IDLE:
//   - access = MemRead | MemWrite.
//   - If access, mem_stall=1 and go to BUSY.
//   - Else, non-memory op: mem_stall=0; the WB bundle is captured at this edge.
// - BUSY:
//   - dmem_req=1; dmem_addr/we/wdata/be are registered and held stable.
//   - mem_stall=1.
//   - On dmem_ready: capture the formatted load data and go to DONE.
// - DONE:
//   - mem_stall=0; the WB bundle is captured; EX/MEM advances at this edge.
//   - Next state is IDLE.
// Latency:
// - Non-memory op: 1 cycle in MEM.
// - Memory op: 3 cycles minimum (dmem_ready in the first BUSY cycle); each extra
//   wait cycle adds 1.
// WB register capture:
// - Captured only when mem_stall=0 (non-memory op in IDLE, or DONE).
// - In any other cycle: wb_valid=0 and wb_RegWrite=0 (bubble); other wb_* fields hold.
// Store formatting (addr[1:0]=a):
// - SB: be=1<<a, wdata={4{rs2[7:0]}}.
// - SH: be=a[1]?1100:0011, wdata={2{rs2[15:0]}}.
// - SW: be=1111, wdata=rs2.
// Load formatting:
// - Select byte a or half a[1] of the read word.
// - Sign-extend for B/H; zero-extend for BU/HU; W passes through.
// - Any other funct3 value is treated as W.
// Boundary conditions:
// - MemRead and MemWrite both set: treated as a store.
// - dmem_ready outside BUSY is ignored.
// - rd=x0 loads complete normally; the register file ignores the write.
// - Back-to-back memory ops: IDLE re-evaluates the new EX/MEM contents in the cycle
//   after DONE; there is no bubble beyond that.
// CONFIGURATION
// - MEM_MISALIGN_TRAP_EN defined:
//   - H with a[0]=1, or W with a!=0, gives no dmem_req and goes directly to DONE.
//   - mem_misaligned=1 for that DONE cycle.
//   - The WB bundle is captured with wb_RegWrite=0.
// - MEM_MISALIGN_TRAP_EN undefined:
//   - mem_misaligned is tied 0.
//   - The low address bits are ignored for the lane: H uses a[1], W uses lane 0.
//   - The access proceeds normally.
// TESTING
// - Each test name below is followed by its required response.
// - ALU op, rd=5, result 0x1234 -> mem_stall stays 0; next cycle wb_valid=1,
//   wb_rd_addr=5, wb_alu_result=0x1234.
// - LB addr 0x103, rdata 0x80FF_0000, ready 1st BUSY cycle -> stall 2 cycles,
//   dmem_addr=0x100, wb_load_data=0xFFFF_FF80.
// - SH addr 0x202, rs2 0xABCD_1234, ready after 3 waits -> dmem_be=1100,
//   dmem_wdata=0x1234_1234, dmem_req held 4 cycles, stall 5 cycles.
// - LHU addr 0x2, rdata 0x9876_0000 then SW immediately -> wb_load_data=0x0000_9876;
//   the store's req rises 2 cycles after the load's DONE edge.
// - rst asserted while BUSY -> dmem_req=0 immediately; after release, IDLE, all wb_*=0.
// - MEM_MISALIGN_TRAP_EN: LW addr 0x5 -> no dmem_req, mem_misaligned 1 cycle,
//   wb_RegWrite=0.

Source files
------------

// File: rtl/mem_stage_access_unit.sv
// rtl/mem_stage_access_unit.sv - MEM-stage data-memory access, load formatting and MEM/WB register
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_stage_access_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] mem_alu_result,
   input  logic [DATA_WIDTH-1:0] mem_rs2_data,
   input  logic [4:0]            mem_rd_addr,
   input  logic [2:0]            mem_funct3,
   input  logic                  mem_MemRead,
   input  logic                  mem_MemWrite,
   input  logic                  mem_MemToReg,
   input  logic                  mem_RegWrite,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [3:0]            dmem_be,
   input  logic                  dmem_ready,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  mem_stall,
   output logic                  wb_valid,
   output logic                  wb_RegWrite,
   output logic                  wb_MemToReg,
   output logic [4:0]            wb_rd_addr,
   output logic [DATA_WIDTH-1:0] wb_alu_result,
   output logic [DATA_WIDTH-1:0] wb_load_data,
   output logic                  mem_misaligned
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                state_q, state_d;
   logic                  dmem_req_q, dmem_req_d;
   logic                  dmem_we_q, dmem_we_d;
   logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
   logic [DATA_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
   logic [3:0]            dmem_be_q, dmem_be_d;
   logic [1:0]            lane_q, lane_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
   logic                  trap_q, trap_d;
   logic                  misaligned_q, misaligned_d;
   logic                  wb_valid_q, wb_valid_d;
   logic                  wb_reg_write_q, wb_reg_write_d;
   logic                  wb_mem_to_reg_q, wb_mem_to_reg_d;
   logic [4:0]            wb_rd_addr_q, wb_rd_addr_d;
   logic [DATA_WIDTH-1:0] wb_alu_result_q, wb_alu_result_d;
   logic [DATA_WIDTH-1:0] wb_load_data_q, wb_load_data_d;

   logic                  access;
   logic [1:0]            lane;
   logic                  misaligned;
   logic [3:0]            st_be;
   logic [DATA_WIDTH-1:0] st_wdata;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] ld_fmt;

   assign access = mem_MemRead | mem_MemWrite;
   assign lane   = mem_alu_result[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
   // funct3[1:0] 00 = byte, 01 = half, anything else behaves as a word
   assign misaligned = access &&
                       (((mem_funct3[1:0] == 2'b01) && lane[0]) ||
                        (mem_funct3[1] && (lane != 2'b00)));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = mem_rs2_data;
      case (mem_funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << lane;
            st_wdata = {4{mem_rs2_data[7:0]}};
         end
         2'b01: begin
            st_be    = lane[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{mem_rs2_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (lane_q)
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_fmt = {24'd0, ld_byte};
         3'b101:  ld_fmt = {16'd0, ld_half};
         default: ld_fmt = dmem_rdata;
      endcase
   end

   always_comb begin
      case (state_q)
         S_IDLE:  mem_stall = access;
         S_BUSY:  mem_stall = 1'b1;
         default: mem_stall = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      dmem_be_d    = dmem_be_q;
      lane_d       = lane_q;
      funct3_d     = funct3_q;
      load_data_d  = load_data_q;
      trap_d       = trap_q;
      misaligned_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access && misaligned) begin
               state_d      = S_DONE;
               trap_d       = 1'b1;
               misaligned_d = 1'b1;
            end else if (access) begin
               state_d      = S_BUSY;
               dmem_req_d   = 1'b1;
               dmem_we_d    = mem_MemWrite;
               dmem_addr_d  = {mem_alu_result[ADDR_WIDTH-1:2], 2'b00};
               dmem_wdata_d = st_wdata;
               dmem_be_d    = mem_MemWrite ? st_be : 4'b0000;
               lane_d       = lane;
               funct3_d     = mem_funct3;
               trap_d       = 1'b0;
            end
         end
         S_BUSY: begin
            if (dmem_ready) begin
               state_d     = S_DONE;
               dmem_req_d  = 1'b0;
               load_data_d = ld_fmt;
            end
         end
         default: begin
            state_d = S_IDLE;
            trap_d  = 1'b0;
         end
      endcase
   end

   // MEM/WB register: bubbles clear only valid and RegWrite, the payload holds
   always_comb begin
      wb_valid_d      = 1'b0;
      wb_reg_write_d  = 1'b0;
      wb_mem_to_reg_d = wb_mem_to_reg_q;
      wb_rd_addr_d    = wb_rd_addr_q;
      wb_alu_result_d = wb_alu_result_q;
      wb_load_data_d  = wb_load_data_q;
      if (!mem_stall) begin
         wb_valid_d      = 1'b1;
         wb_reg_write_d  = mem_RegWrite & ~trap_q;
         wb_mem_to_reg_d = mem_MemToReg;
         wb_rd_addr_d    = mem_rd_addr;
         wb_alu_result_d = mem_alu_result;
         wb_load_data_d  = load_data_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         dmem_req_q      <= 1'b0;
         dmem_we_q       <= 1'b0;
         dmem_addr_q     <= '0;
         dmem_wdata_q    <= '0;
         dmem_be_q       <= 4'b0000;
         lane_q          <= 2'b00;
         funct3_q        <= 3'b000;
         load_data_q     <= '0;
         trap_q          <= 1'b0;
         misaligned_q    <= 1'b0;
         wb_valid_q      <= 1'b0;
         wb_reg_write_q  <= 1'b0;
         wb_mem_to_reg_q <= 1'b0;
         wb_rd_addr_q    <= 5'd0;
         wb_alu_result_q <= '0;
         wb_load_data_q  <= '0;
      end else begin
         state_q         <= state_d;
         dmem_req_q      <= dmem_req_d;
         dmem_we_q       <= dmem_we_d;
         dmem_addr_q     <= dmem_addr_d;
         dmem_wdata_q    <= dmem_wdata_d;
         dmem_be_q       <= dmem_be_d;
         lane_q          <= lane_d;
         funct3_q        <= funct3_d;
         load_data_q     <= load_data_d;
         trap_q          <= trap_d;
         misaligned_q    <= misaligned_d;
         wb_valid_q      <= wb_valid_d;
         wb_reg_write_q  <= wb_reg_write_d;
         wb_mem_to_reg_q <= wb_mem_to_reg_d;
         wb_rd_addr_q    <= wb_rd_addr_d;
         wb_alu_result_q <= wb_alu_result_d;
         wb_load_data_q  <= wb_load_data_d;
      end
   end

   assign dmem_req       = dmem_req_q;
   assign dmem_we        = dmem_we_q;
   assign dmem_addr      = dmem_addr_q;
   assign dmem_wdata     = dmem_wdata_q;
   assign dmem_be        = dmem_be_q;
   assign mem_misaligned = misaligned_q;
   assign wb_valid       = wb_valid_q;
   assign wb_RegWrite    = wb_reg_write_q;
   assign wb_MemToReg    = wb_mem_to_reg_q;
   assign wb_rd_addr     = wb_rd_addr_q;
   assign wb_alu_result  = wb_alu_result_q;
   assign wb_load_data   = wb_load_data_q;

endmodule
